// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared constants and helpers for the VGA raster timing generator.
//   - 640x480@60 default timing (pixels / lines, active-low syncs)
//   - axis_total(): line or frame length from its four regions
//   - min_cw():     smallest counter width whose range strictly exceeds a total
//   - raw_sync_t:   the per-pixel flags carried down the latency delay line
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam bit DEF_H_POL    = 1'b0;
  localparam bit DEF_V_POL    = 1'b0;

  localparam int DEF_PIX_DIV  = 4;
  localparam int DEF_LAT      = 2;
  localparam int DEF_CW       = 12;
  localparam int DEF_RGB_W    = 24;

  // Flags describing one pixel position; delayed together so they stay aligned.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } raw_sync_t;

  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // A total of 2^CW is rejected as well, so the width must hold the total itself.
  function automatic int min_cw(input int total);
    return $clog2(total + 1);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One raster axis (horizontal or vertical). Counts 0..TOT-1 when en is high and
// decodes the region the count is in. Region order: active, FP, sync, BP.
//   clk      in   system clock
//   reset    in   synchronous, active-high
//   en       in   advance the count by one
//   cnt      out  current position on the axis
//   active   out  cnt inside [0, ACTIVE)
//   in_sync  out  cnt inside [ACTIVE+FP, ACTIVE+FP+SYNC)
//   wrap     out  cnt is the last position; the next advance returns to 0
// -----------------------------------------------------------------------------
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter int CW     = DEF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          active,
  output logic          in_sync,
  output logic          wrap
);

  localparam int TOT = axis_total(ACTIVE, FP, SYNC, BP);

  localparam logic [CW-1:0] LAST     = CW'(TOT - 1);
  localparam logic [CW-1:0] ACT_END  = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_BEG = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_END = CW'(ACTIVE + FP + SYNC);

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + CW'(1);
    end
  end

  assign wrap    = (cnt == LAST);
  assign active  = (cnt < ACT_END);
  assign in_sync = (cnt >= SYNC_BEG) && (cnt < SYNC_END);

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA raster timing generator with a latency-matched pixel path.
// Presents pixel coordinates to the renderer, takes its colour back LAT pixel
// ticks later, and drives hsync/vsync/de/rgb_out cycle-aligned with each other.
//   clk          in   system clock
//   reset        in   synchronous, active-high
//   pix_x/pix_y  out  pixel currently requested (horizontal / vertical count)
//   pix_req      out  requested pixel lies inside the visible area
//   pix_tick     out  one-clk pulse per pixel period (constant 1 when PIX_DIV=1)
//   frame_start  out  one-clk pulse on the tick that wraps the frame to (0,0)
//   rgb_in       in   renderer colour for the pixel requested LAT ticks earlier
//   hsync/vsync  out  sync outputs, asserted level set by H_POL / V_POL
//   de           out  data enable, aligned with rgb_out
//   rgb_out      out  output colour, forced to 0 outside the visible area
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit H_POL    = DEF_H_POL,
  parameter bit V_POL    = DEF_V_POL,
  parameter int PIX_DIV  = DEF_PIX_DIV,
  parameter int LAT      = DEF_LAT,
  parameter int CW       = DEF_CW,
  parameter int RGB_W    = DEF_RGB_W
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CW-1:0]    pix_x,
  output logic [CW-1:0]    pix_y,
  output logic             pix_req,
  output logic             pix_tick,
  output logic             frame_start,
  input  logic [RGB_W-1:0] rgb_in,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [RGB_W-1:0] rgb_out
);

  localparam int H_TOT = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (CW < min_cw(H_TOT) || CW < min_cw(V_TOT) || PIX_DIV < 1 || LAT < 1) begin : g_param_error
    $error("vga_timing_gen: illegal parameters H_TOT=%0d V_TOT=%0d CW=%0d PIX_DIV=%0d LAT=%0d",
           H_TOT, V_TOT, CW, PIX_DIV, LAT);
  end

  // ---------------------------------------------------------------------------
  // Pixel-clock divider
  // ---------------------------------------------------------------------------
  localparam int                 DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(PIX_DIV - 1);

  logic [DIV_W-1:0] div;

  always_ff @(posedge clk) begin
    if (reset || div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Gated by reset so the tick reads 0 while reset is held, even at PIX_DIV=1
  // where the divider alone would make it permanently high.
  assign pix_tick = !reset && (div == DIV_LAST);

  // ---------------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------------
  logic h_active, h_sync, h_wrap;
  logic v_active, v_sync, v_wrap;
  logic v_en;

  assign v_en = pix_tick && h_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .CW     (CW)
  ) u_h_axis (
    .clk     (clk),
    .reset   (reset),
    .en      (pix_tick),
    .cnt     (pix_x),
    .active  (h_active),
    .in_sync (h_sync),
    .wrap    (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .CW     (CW)
  ) u_v_axis (
    .clk     (clk),
    .reset   (reset),
    .en      (v_en),
    .cnt     (pix_y),
    .active  (v_active),
    .in_sync (v_sync),
    .wrap    (v_wrap)
  );

  raw_sync_t raw_now;
  raw_sync_t raw_last;

  assign raw_now     = '{de: h_active && v_active, hs: h_sync, vs: v_sync};
  assign pix_req     = raw_now.de;
  assign frame_start = pix_tick && h_wrap && v_wrap;

  // ---------------------------------------------------------------------------
  // Latency delay line: LAT-1 stages here, the output register is the last one,
  // so the flags for a pixel reach the pins on the same edge as its colour.
  // ---------------------------------------------------------------------------
  if (LAT == 1) begin : g_no_delay
    assign raw_last = raw_now;
  end else begin : g_delay
    raw_sync_t dly_q [LAT-1];

    // NOTE: the delay line is reset because its contents reach the pins
    // directly; stale sync flags after reset would emit a spurious pulse.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < LAT - 1; i++) dly_q[i] <= '0;
      end else if (pix_tick) begin
        dly_q[0] <= raw_now;
        for (int i = 1; i < LAT - 1; i++) dly_q[i] <= dly_q[i-1];
      end
    end

    assign raw_last = dly_q[LAT-2];
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync   <= ~H_POL;
      vsync   <= ~V_POL;
      de      <= 1'b0;
      rgb_out <= '0;
    end else if (pix_tick) begin
      hsync   <= raw_last.hs ~^ H_POL;
      vsync   <= raw_last.vs ~^ V_POL;
      de      <= raw_last.de;
      rgb_out <= raw_last.de ? rgb_in : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Three generators with small timing (H 8/2/3/1, V 4/1/2/1) and different
// divider / latency / polarity settings run side by side. A reference model
// derives every output from the number of clk edges since the last reset edge,
// and the renderer side supplies a pseudo-random colour per pixel index.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int HA = 8, HFP = 2, HS = 3, HBP = 1;
  localparam int VA = 4, VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;  // 14
  localparam int VT = VA + VFP + VS + VBP;  // 8
  localparam int ND = 3;

  typedef struct {
    int div;
    int lat;
    bit hpol;
    bit vpol;
  } cfg_t;

  typedef struct {
    logic [11:0] x, y;
    logic        req, tick, fs, hs, vs, de;
    logic [23:0] rgb;
  } exp_t;

  function automatic cfg_t cfg(int i);
    cfg_t c;
    case (i)
      0:       begin c.div = 1; c.lat = 2; c.hpol = 1'b0; c.vpol = 1'b0; end
      1:       begin c.div = 4; c.lat = 3; c.hpol = 1'b1; c.vpol = 1'b1; end
      default: begin c.div = 3; c.lat = 1; c.hpol = 1'b0; c.vpol = 1'b1; end
    endcase
    return c;
  endfunction

  logic        clk = 1'b0;
  logic        rst    [ND];
  logic [23:0] rgb_in [ND];
  logic [11:0] px     [ND];
  logic [11:0] py     [ND];
  logic        req    [ND];
  logic        tick   [ND];
  logic        fs     [ND];
  logic        hs     [ND];
  logic        vs     [ND];
  logic        de     [ND];
  logic [23:0] rgb    [ND];

  int          n      [ND];
  bit          valid  [ND];
  logic [31:0] seed   [ND];
  int          rcnt   [ND];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .H_POL(1'b0), .V_POL(1'b0), .PIX_DIV(1), .LAT(2), .CW(12), .RGB_W(24)
  ) u_a (
    .clk(clk), .reset(rst[0]), .pix_x(px[0]), .pix_y(py[0]), .pix_req(req[0]),
    .pix_tick(tick[0]), .frame_start(fs[0]), .rgb_in(rgb_in[0]),
    .hsync(hs[0]), .vsync(vs[0]), .de(de[0]), .rgb_out(rgb[0])
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .H_POL(1'b1), .V_POL(1'b1), .PIX_DIV(4), .LAT(3), .CW(12), .RGB_W(24)
  ) u_b (
    .clk(clk), .reset(rst[1]), .pix_x(px[1]), .pix_y(py[1]), .pix_req(req[1]),
    .pix_tick(tick[1]), .frame_start(fs[1]), .rgb_in(rgb_in[1]),
    .hsync(hs[1]), .vsync(vs[1]), .de(de[1]), .rgb_out(rgb[1])
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .H_POL(1'b0), .V_POL(1'b1), .PIX_DIV(3), .LAT(1), .CW(12), .RGB_W(24)
  ) u_c (
    .clk(clk), .reset(rst[2]), .pix_x(px[2]), .pix_y(py[2]), .pix_req(req[2]),
    .pix_tick(tick[2]), .frame_start(fs[2]), .rgb_in(rgb_in[2]),
    .hsync(hs[2]), .vsync(vs[2]), .de(de[2]), .rgb_out(rgb[2])
  );

  // Edges since the last edge that saw reset high.
  always @(posedge clk) begin
    for (int i = 0; i < ND; i++) begin
      if (rst[i]) begin
        n[i]     <= 0;
        valid[i] <= 1'b1;
      end else begin
        n[i] <= n[i] + 1;
      end
    end
  end

  function automatic logic [23:0] colour(int i, int p);
    logic [31:0] h;
    h = (32'(p) * 32'h9E37_79B1) ^ seed[i];
    h = h ^ (h >> 15);
    return h[23:0];
  endfunction

  // Pixel k is requested after k ticks; pixel k-LAT is on the output pins.
  function automatic exp_t model(int i, int edges, bit rst_now);
    cfg_t c;
    exp_t e;
    int   k, p, ox, oy;
    c      = cfg(i);
    k      = edges / c.div;
    e.x    = 12'(k % HT);
    e.y    = 12'((k / HT) % VT);
    e.req  = ((k % HT) < HA) && (((k / HT) % VT) < VA);
    e.tick = !rst_now && ((edges % c.div) == c.div - 1);
    e.fs   = e.tick && ((k % HT) == HT - 1) && (((k / HT) % VT) == VT - 1);
    if (k < c.lat) begin
      e.de  = 1'b0;
      e.hs  = !c.hpol;
      e.vs  = !c.vpol;
      e.rgb = '0;
    end else begin
      p     = k - c.lat;
      ox    = p % HT;
      oy    = (p / HT) % VT;
      e.de  = (ox < HA) && (oy < VA);
      e.hs  = (ox >= HA + HFP && ox < HA + HFP + HS) ? c.hpol : !c.hpol;
      e.vs  = (oy >= VA + VFP && oy < VA + VFP + VS) ? c.vpol : !c.vpol;
      e.rgb = e.de ? colour(i, p) : 24'd0;
    end
    return e;
  endfunction

  task automatic check(int dut, string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL u%0d %s: got %0h, expected %0h (t=%0t)", dut, name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    exp_t e;
    for (int i = 0; i < ND; i++) begin
      if (valid[i]) begin
        e = model(i, n[i], rst[i]);
        check(i, "pix_x",       32'(px[i]),   32'(e.x));
        check(i, "pix_y",       32'(py[i]),   32'(e.y));
        check(i, "pix_req",     32'(req[i]),  32'(e.req));
        check(i, "pix_tick",    32'(tick[i]), 32'(e.tick));
        check(i, "frame_start", 32'(fs[i]),   32'(e.fs));
        check(i, "hsync",       32'(hs[i]),   32'(e.hs));
        check(i, "vsync",       32'(vs[i]),   32'(e.vs));
        check(i, "de",          32'(de[i]),   32'(e.de));
        check(i, "rgb_out",     32'(rgb[i]),  32'(e.rgb));
      end
    end
  endtask

  // Called just after a negedge: sets reset for the coming edge and, when that
  // edge carries a tick, presents the colour the DUT must capture on it.
  task automatic drive(int i, bit r);
    cfg_t c;
    int   p;
    c     = cfg(i);
    rst[i] = r;
    if (!r && valid[i] && ((n[i] % c.div) == c.div - 1)) begin
      p = n[i] / c.div + 1 - c.lat;
      rgb_in[i] = (p >= 0) ? colour(i, p) : 24'($urandom);
    end else begin
      rgb_in[i] = 24'($urandom);
    end
  endtask

  int first_hs_a, first_hs_b, hs_lo_a, de_hi_a, vs_lo_a, fs_cnt_a, fs_n_a;
  int tick_b, hs_hi_b, nn;
  bit found;

  initial begin
    for (int i = 0; i < ND; i++) begin
      seed[i]   = $urandom;
      rst[i]    = 1'b1;
      rgb_in[i] = 24'($urandom);
      rcnt[i]   = 0;
    end

    // Reset values.
    repeat (2) @(negedge clk);
    compare_all();
    check(0, "rst_hsync",    32'(hs[0]),   32'd1);
    check(1, "rst_hsync",    32'(hs[1]),   32'd0);
    check(1, "rst_vsync",    32'(vs[1]),   32'd0);
    check(2, "rst_vsync",    32'(vs[2]),   32'd0);
    check(0, "rst_pix_tick", 32'(tick[0]), 32'd0);
    check(0, "rst_de",       32'(de[0]),   32'd0);
    check(0, "rst_rgb_out",  32'(rgb[0]),  32'd0);
    check(1, "rst_pix_x",    32'(px[1]),   32'd0);
    for (int i = 0; i < ND; i++) drive(i, 1'b0);

    // Cold start: one full frame plus pipeline fill, with measured pulse counts.
    first_hs_a = -1; first_hs_b = -1;
    hs_lo_a = 0; de_hi_a = 0; vs_lo_a = 0; fs_cnt_a = 0; fs_n_a = -1;
    tick_b = 0; hs_hi_b = 0;
    for (int c = 0; c < 470; c++) begin
      @(negedge clk);
      compare_all();
      nn = n[0];
      if (hs[0] == 1'b0 && first_hs_a < 0) first_hs_a = nn;
      if (hs[1] == 1'b1 && first_hs_b < 0) first_hs_b = nn;
      if (nn >= 2 && nn < 114) begin
        if (!hs[0]) hs_lo_a++;
        if (de[0])  de_hi_a++;
        if (!vs[0]) vs_lo_a++;
      end
      if (nn >= 1 && nn < 113 && fs[0]) begin
        fs_cnt_a++;
        fs_n_a = nn;
      end
      if (nn == 3) check(1, "pix_x_before_first_step", 32'(px[1]), 32'd0);
      if (nn == 4) check(1, "pix_x_first_step",        32'(px[1]), 32'd1);
      if (nn >= 1 && nn < 41 && tick[1]) tick_b++;
      if (nn >= 12 && nn < 460 && hs[1]) hs_hi_b++;
      for (int i = 0; i < ND; i++) drive(i, 1'b0);
    end
    check(0, "first_hsync_low_edge", 32'(first_hs_a), 32'd12);
    check(0, "hsync_low_per_frame",  32'(hs_lo_a),    32'd24);
    check(0, "de_high_per_frame",    32'(de_hi_a),    32'd32);
    check(0, "vsync_low_per_frame",  32'(vs_lo_a),    32'd28);
    check(0, "frame_start_count",    32'(fs_cnt_a),   32'd1);
    check(0, "frame_start_edge",     32'(fs_n_a),     32'd111);
    check(1, "pix_tick_in_40_clks",  32'(tick_b),     32'd10);
    check(1, "hsync_high_per_frame", 32'(hs_hi_b),    32'd96);
    check(1, "first_hsync_high",     32'(first_hs_b), 32'd52);

    // Mid-frame reset of u0 while its hsync pulse is in progress.
    found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      @(negedge clk);
      compare_all();
      if (px[0] == 12'd13 && py[0] == 12'd5) begin
        found = 1'b1;
        check(0, "hsync_mid_pulse", 32'(hs[0]), 32'd0);
        drive(0, 1'b1);
      end else begin
        drive(0, 1'b0);
      end
      drive(1, 1'b0);
      drive(2, 1'b0);
    end
    check(0, "reached_13_5", 32'(found), 32'd1);
    @(negedge clk);
    compare_all();
    check(0, "mid_rst_pix_x",   32'(px[0]),  32'd0);
    check(0, "mid_rst_pix_y",   32'(py[0]),  32'd0);
    check(0, "mid_rst_hsync",   32'(hs[0]),  32'd1);
    check(0, "mid_rst_de",      32'(de[0]),  32'd0);
    check(0, "mid_rst_rgb_out", 32'(rgb[0]), 32'd0);
    for (int i = 0; i < ND; i++) drive(i, 1'b0);

    // Free run with sporadic random resets on each generator.
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      compare_all();
      for (int i = 0; i < ND; i++) begin
        if (rcnt[i] == 0 && $urandom_range(0, 1499) == 0) rcnt[i] = $urandom_range(1, 3);
        if (rcnt[i] > 0) begin
          rcnt[i]--;
          drive(i, 1'b1);
        end else begin
          drive(i, 1'b0);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
